// File: rtl/swu_fm_pad_pkg.sv
// Shared helpers for the swu feature-map padding stage: derived frame dimensions,
// counter widths and the pad-slot predicate.
package swu_fm_pad_pkg;

    // Classification of one output slot of the padded frame.
    typedef enum logic {
        SlotData = 1'b0,
        SlotPad  = 1'b1
    } slot_kind_e;

    // Channel folds per pixel.
    function automatic int unsigned swu_cf(input int unsigned channels,
                                           input int unsigned simd);
        return channels / simd;
    endfunction

    // Padded extent of one dimension.
    function automatic int unsigned swu_padded_dim(input int unsigned dim,
                                                   input int unsigned pad_lo,
                                                   input int unsigned pad_hi);
        return dim + pad_lo + pad_hi;
    endfunction

    // Bits needed to count 0..max_val; never narrower than one bit.
    function automatic int unsigned swu_cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // A slot is pad when it falls outside the unpadded IFM window.
    function automatic slot_kind_e swu_slot_kind(input int unsigned row,
                                                 input int unsigned col,
                                                 input int unsigned pad_top,
                                                 input int unsigned ifm_h,
                                                 input int unsigned pad_left,
                                                 input int unsigned ifm_w);
        if ((row < pad_top) || (row >= pad_top + ifm_h) ||
            (col < pad_left) || (col >= pad_left + ifm_w)) begin
            return SlotPad;
        end
        return SlotData;
    endfunction

endpackage

// File: rtl/swu_fm_pad_if.sv
// AXI-Stream style beat interface used on both sides of swu_fm_pad.
// With SWU_PAD_TLAST_EN defined the master side also carries tlast.
interface swu_fm_pad_if #(
    parameter int unsigned DataWidth = 8
);
    logic [DataWidth-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

`ifdef SWU_PAD_TLAST_EN
    logic                 tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );
`else
    modport master (
        output tdata,
        output tvalid,
        input  tready
    );
`endif

    // The padding stage never consumes tlast on its input side.
    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/swu_fm_pad_cnt.sv
// Nested cf -> ox -> oy position counter over one padded frame. Reports whether the
// current slot is pad and whether it is the last beat of the frame.
module swu_fm_pad_cnt
    import swu_fm_pad_pkg::*;
#(
    parameter int unsigned NumFold   = 2,
    parameter int unsigned OutWidth  = 8,
    parameter int unsigned OutHeight = 8,
    parameter int unsigned IfmWidth  = 6,
    parameter int unsigned IfmHeight = 6,
    parameter int unsigned PadTop    = 1,
    parameter int unsigned PadLeft   = 1,
    localparam int unsigned CfW      = swu_cnt_w(NumFold - 1),
    localparam int unsigned OxW      = swu_cnt_w(OutWidth - 1),
    localparam int unsigned OyW      = swu_cnt_w(OutHeight - 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           advance_i,
    output logic [CfW-1:0] cf_o,
    output logic [OxW-1:0] ox_o,
    output logic [OyW-1:0] oy_o,
    output logic           is_pad_o,
    output logic           frame_end_o
);

    localparam logic [CfW-1:0] CfLast = CfW'(NumFold - 1);
    localparam logic [OxW-1:0] OxLast = OxW'(OutWidth - 1);
    localparam logic [OyW-1:0] OyLast = OyW'(OutHeight - 1);

    logic [CfW-1:0] cf_q, cf_d;
    logic [OxW-1:0] ox_q, ox_d;
    logic [OyW-1:0] oy_q, oy_d;
    logic           cf_last, ox_last, oy_last;

    // Wrap detection and slot classification for the current position.
    always_comb begin
        cf_last     = (cf_q == CfLast);
        ox_last     = (ox_q == OxLast);
        oy_last     = (oy_q == OyLast);
        frame_end_o = cf_last && ox_last && oy_last;
        is_pad_o    = (swu_slot_kind(32'(oy_q), 32'(ox_q), PadTop, IfmHeight,
                                     PadLeft, IfmWidth) == SlotPad);
    end

    // Ripple the fold counter into column, then row; all wrap together at frame end.
    always_comb begin
        cf_d = cf_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (advance_i) begin
            if (cf_last) begin
                cf_d = '0;
                if (ox_last) begin
                    ox_d = '0;
                    oy_d = oy_last ? '0 : oy_q + OyW'(1);
                end else begin
                    ox_d = ox_q + OxW'(1);
                end
            end else begin
                cf_d = cf_q + CfW'(1);
            end
        end
    end

    // Position registers; reset discards any partial frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cf_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            cf_q <= cf_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    assign cf_o = cf_q;
    assign ox_o = ox_q;
    assign oy_o = oy_q;

endmodule

// File: rtl/swu_fm_pad.sv
// Feature-map padding stage ahead of the sliding window unit. Emits the padded IFM
// stream through a single output register; pad beats are generated locally without
// consuming input. Define SWU_PAD_TLAST_EN to add a registered m_axis.tlast that
// marks the final beat of each padded frame.
module swu_fm_pad
    import swu_fm_pad_pkg::*;
#(
    parameter int unsigned SIMD         = 1,
    parameter int unsigned IP_PRECISION = 8,
    parameter int unsigned IFMChannels  = 2,
    parameter int unsigned IFMWidth     = 6,
    parameter int unsigned IFMHeight    = 6,
    parameter int unsigned PAD_TOP      = 1,
    parameter int unsigned PAD_BOTTOM   = 1,
    parameter int unsigned PAD_LEFT     = 1,
    parameter int unsigned PAD_RIGHT    = 1,
    parameter logic [IP_PRECISION-1:0] PAD_VALUE = '0
) (
    input  logic         aclk,
    input  logic         areset,
    swu_fm_pad_if.slave  s_axis,
    swu_fm_pad_if.master m_axis
);

    localparam int unsigned NumFold   = swu_cf(IFMChannels, SIMD);
    localparam int unsigned OutWidth  = swu_padded_dim(IFMWidth, PAD_LEFT, PAD_RIGHT);
    localparam int unsigned OutHeight = swu_padded_dim(IFMHeight, PAD_TOP, PAD_BOTTOM);
    localparam int unsigned DataWidth = SIMD * IP_PRECISION;
    localparam int unsigned CfW       = swu_cnt_w(NumFold - 1);
    localparam int unsigned OxW       = swu_cnt_w(OutWidth - 1);
    localparam int unsigned OyW       = swu_cnt_w(OutHeight - 1);

    localparam logic [DataWidth-1:0] PadBeat = {SIMD{PAD_VALUE}};

    if ((SIMD == 0) || (IFMChannels % SIMD != 0)) begin : g_bad_simd
        $error("swu_fm_pad: SIMD must be nonzero and divide IFMChannels");
    end
    if ((IFMWidth == 0) || (IFMHeight == 0)) begin : g_bad_dims
        $error("swu_fm_pad: IFMWidth and IFMHeight must be nonzero");
    end

    logic [CfW-1:0]       cf;
    logic [OxW-1:0]       ox;
    logic [OyW-1:0]       oy;
    logic                 is_pad;
    logic                 frame_end;
    logic                 load;
    logic                 advance;

    logic [DataWidth-1:0] tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
`ifdef SWU_PAD_TLAST_EN
    logic                 tlast_q, tlast_d;
`endif

    swu_fm_pad_cnt #(
        .NumFold   (NumFold),
        .OutWidth  (OutWidth),
        .OutHeight (OutHeight),
        .IfmWidth  (IFMWidth),
        .IfmHeight (IFMHeight),
        .PadTop    (PAD_TOP),
        .PadLeft   (PAD_LEFT)
    ) u_cnt (
        .clk_i       (aclk),
        .rst_i       (areset),
        .advance_i   (advance),
        .cf_o        (cf),
        .ox_o        (ox),
        .oy_o        (oy),
        .is_pad_o    (is_pad),
        .frame_end_o (frame_end)
    );

    // Handshake: the register may load when empty or draining; input is only taken
    // on data slots, and a pad slot advances on its own.
    always_comb begin
        load          = !tvalid_q || m_axis.tready;
        s_axis.tready = !areset && load && !is_pad;
        advance       = !areset && load && (is_pad || s_axis.tvalid);
    end

    // Next contents of the output register.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
`ifdef SWU_PAD_TLAST_EN
        tlast_d  = tlast_q;
`endif
        if (load) begin
            tvalid_d = advance;
            if (is_pad) begin
                tdata_d = PadBeat;
            end else if (s_axis.tvalid) begin
                tdata_d = s_axis.tdata;
            end
`ifdef SWU_PAD_TLAST_EN
            tlast_d = advance && frame_end;
`endif
        end
    end

    // Output register; cleared by reset so nothing of the partial frame leaks out.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
`ifdef SWU_PAD_TLAST_EN
            tlast_q  <= 1'b0;
`endif
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
`ifdef SWU_PAD_TLAST_EN
            tlast_q  <= tlast_d;
`endif
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
`ifdef SWU_PAD_TLAST_EN
    assign m_axis.tlast  = tlast_q;
`endif

    // Counters never leave the padded frame; frame_end only fires at the final position.
    a_cnt_range: assert property (@(posedge aclk) disable iff (areset)
        (32'(cf) < NumFold) && (32'(ox) < OutWidth) && (32'(oy) < OutHeight));
    a_frame_end: assert property (@(posedge aclk) disable iff (areset)
        frame_end |-> ((32'(cf) == NumFold - 1) && (32'(ox) == OutWidth - 1) &&
                       (32'(oy) == OutHeight - 1)));

endmodule

// File: tb/tb_swu_fm_pad.sv
// Bench for swu_fm_pad: three configurations run side by side against a frame-position
// reference model, with directed phases plus random valid/ready.
module tb_swu_fm_pad;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Per-DUT configuration: 0 = 4x4 C2 pads 1; 1 = 3x3 C4 SIMD2 no pads; 2 = 2x2 asym pads.
    int          c_iw [3] = '{4, 3, 2};
    int          c_ih [3] = '{4, 3, 2};
    int          c_cf [3] = '{2, 2, 1};
    int          c_pt [3] = '{1, 0, 0};
    int          c_pb [3] = '{1, 0, 2};
    int          c_pl [3] = '{1, 0, 2};
    int          c_pr [3] = '{1, 0, 0};
    logic [31:0] c_pad[3] = '{32'h0, 32'h0, 32'h80};
    logic [31:0] c_msk[3] = '{32'hff, 32'hffff, 32'hff};

    // Model / monitor state.
    int          n_out   [3];
    int          in_idx  [3];
    bit          rst_prev[3];
    bit          hold    [3];
    logic [31:0] held    [3];
    logic [31:0] out_log [3][256];
    int          out_cyc [3][256];
    int          in_cyc  [3][256];
    int          tl_q[$];
    int          vmode[3] = '{3, 3, 3};
    int          rmode[3] = '{3, 3, 3};
    logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    swu_fm_pad_if #(.DataWidth(8))  sa ();
    swu_fm_pad_if #(.DataWidth(8))  ma ();
    swu_fm_pad_if #(.DataWidth(16)) sb ();
    swu_fm_pad_if #(.DataWidth(16)) mb ();
    swu_fm_pad_if #(.DataWidth(8))  sc ();
    swu_fm_pad_if #(.DataWidth(8))  mc ();

    swu_fm_pad #(
        .SIMD(1), .IP_PRECISION(8), .IFMChannels(2), .IFMWidth(4), .IFMHeight(4),
        .PAD_TOP(1), .PAD_BOTTOM(1), .PAD_LEFT(1), .PAD_RIGHT(1), .PAD_VALUE(8'h00)
    ) dut_a (.aclk(clk), .areset(rst_a), .s_axis(sa), .m_axis(ma));

    swu_fm_pad #(
        .SIMD(2), .IP_PRECISION(8), .IFMChannels(4), .IFMWidth(3), .IFMHeight(3),
        .PAD_TOP(0), .PAD_BOTTOM(0), .PAD_LEFT(0), .PAD_RIGHT(0), .PAD_VALUE(8'h00)
    ) dut_b (.aclk(clk), .areset(rst_b), .s_axis(sb), .m_axis(mb));

    swu_fm_pad #(
        .SIMD(1), .IP_PRECISION(8), .IFMChannels(1), .IFMWidth(2), .IFMHeight(2),
        .PAD_TOP(0), .PAD_BOTTOM(2), .PAD_LEFT(2), .PAD_RIGHT(0), .PAD_VALUE(8'h80)
    ) dut_c (.aclk(clk), .areset(rst_c), .s_axis(sc), .m_axis(mc));

    logic tl_a, tl_b, tl_c;
`ifdef SWU_PAD_TLAST_EN
    assign tl_a = ma.tlast;
    assign tl_b = mb.tlast;
    assign tl_c = mc.tlast;
`else
    assign tl_a = 1'b0;
    assign tl_b = 1'b0;
    assign tl_c = 1'b0;
`endif

    function automatic logic [31:0] gen(int k);
        logic [31:0] x;
        x = 32'(k) * 32'h0100_0193 + 32'h5a5a_1234;
        return x ^ (x >> 13);
    endfunction

    function automatic int fr(int id);
        return (c_iw[id] + c_pl[id] + c_pr[id]) * (c_ih[id] + c_pt[id] + c_pb[id]) * c_cf[id];
    endfunction

    // Padded-frame position of global output beat n.
    function automatic void pos(int id, int n, output int f, output int oy, output int ox,
                                output int c);
        int ow, p;
        ow = c_iw[id] + c_pl[id] + c_pr[id];
        f  = n / fr(id);
        p  = n % fr(id);
        c  = p % c_cf[id];
        ox = (p / c_cf[id]) % ow;
        oy = p / (c_cf[id] * ow);
    endfunction

    function automatic bit slot_pad(int id, int n);
        int f, oy, ox, c;
        pos(id, n, f, oy, ox, c);
        return (oy < c_pt[id]) || (oy >= c_pt[id] + c_ih[id]) ||
               (ox < c_pl[id]) || (ox >= c_pl[id] + c_iw[id]);
    endfunction

    function automatic logic [31:0] exp_data(int id, int n);
        int f, oy, ox, c, k;
        if (slot_pad(id, n)) return c_pad[id];
        pos(id, n, f, oy, ox, c);
        k = f * c_iw[id] * c_ih[id] * c_cf[id] +
            ((oy - c_pt[id]) * c_iw[id] + (ox - c_pl[id])) * c_cf[id] + c;
        return gen(k) & c_msk[id];
    endfunction

    task automatic check(int id, string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL dut%0d %s @cyc %0d: got %h expected %h", id, name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of one DUT against the model.
    task automatic mon(int id, bit rst, bit sv, bit sr, bit mv, bit mr, logic [31:0] md, bit ml);
        int n;
        if (rst) begin
            check(id, "rst_s_ready", 32'(sr), 0);
            if (rst_prev[id]) begin
                check(id, "rst_valid", 32'(mv), 0);
                check(id, "rst_data", md, 0);
`ifdef SWU_PAD_TLAST_EN
                check(id, "rst_tlast", 32'(ml), 0);
`endif
            end
            n_out[id]  = 0;
            in_idx[id] = 0;
            hold[id]   = 1'b0;
            if (id == 0) tl_q.delete();
        end else begin
            n = n_out[id];
            if (hold[id]) begin
                check(id, "stall_valid", 32'(mv), 1);
                check(id, "stall_data", md, held[id]);
            end
            check(id, "s_ready", 32'(sr), 32'(!slot_pad(id, n + int'(mv)) && (!mv || mr)));
            if (mv) begin
                check(id, "data", md, exp_data(id, n));
`ifdef SWU_PAD_TLAST_EN
                check(id, "tlast", 32'(ml), 32'((n % fr(id)) == fr(id) - 1));
                if (ml && id == 0) tl_q.push_back(n);
`endif
            end
            if (mv && mr) begin
                if (n < 256) begin
                    out_log[id][n] = md;
                    out_cyc[id][n] = cyc;
                end
                n_out[id] = n + 1;
            end
            if (sv && sr) begin
                if (in_idx[id] < 256) in_cyc[id][in_idx[id]] = cyc;
                in_idx[id] = in_idx[id] + 1;
            end
            hold[id] = mv && !mr;
            held[id] = md;
        end
        rst_prev[id] = rst;
    endtask

    always @(negedge clk) mon(0, rst_a, sa.tvalid, sa.tready, ma.tvalid, ma.tready,
                              32'(ma.tdata), tl_a);
    always @(negedge clk) mon(1, rst_b, sb.tvalid, sb.tready, mb.tvalid, mb.tready,
                              32'(mb.tdata), tl_b);
    always @(negedge clk) mon(2, rst_c, sc.tvalid, sc.tready, mc.tvalid, mc.tready,
                              32'(mc.tdata), tl_c);

    // 0: always, 1: 4 on / 3 off, 2: random 75%, otherwise never.
    function automatic bit want(int mode);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 7) < 4;
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        sa.tvalid = 1'b0; sa.tdata = '0; ma.tready = 1'b0;
`ifdef SWU_PAD_TLAST_EN
        sa.tlast = 1'b0;
`endif
        forever begin
            @(posedge clk); #1;
            sa.tvalid = want(vmode[0]);
            sa.tdata  = 8'(gen(in_idx[0]));
            ma.tready = want(rmode[0]);
        end
    end

    initial begin
        sb.tvalid = 1'b0; sb.tdata = '0; mb.tready = 1'b0;
`ifdef SWU_PAD_TLAST_EN
        sb.tlast = 1'b0;
`endif
        forever begin
            @(posedge clk); #1;
            sb.tvalid = want(vmode[1]);
            sb.tdata  = 16'(gen(in_idx[1]));
            mb.tready = want(rmode[1]);
        end
    end

    initial begin
        sc.tvalid = 1'b0; sc.tdata = '0; mc.tready = 1'b0;
`ifdef SWU_PAD_TLAST_EN
        sc.tlast = 1'b0;
`endif
        forever begin
            @(posedge clk); #1;
            sc.tvalid = want(vmode[2]);
            sc.tdata  = 8'(gen(in_idx[2]));
            mc.tready = want(rmode[2]);
        end
    end

    task automatic wait_n(int id, int target);
        int budget = 0;
        while (n_out[id] < target && budget < 4000) begin
            @(posedge clk);
            budget++;
        end
        check(id, "reach_out_count", 32'(n_out[id] >= target), 1);
    endtask

    logic [31:0] exp_c[16];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        fork
            begin : run_a
                vmode[0] = 0; rmode[0] = 0;
                wait_n(0, 72);
                check(0, "inputs_per_frame", in_idx[0], 32);
                check(0, "beat13_pad", out_log[0][13], 32'h00);
                check(0, "beat14_in0", out_log[0][14], gen(0) & 32'hff);
                check(0, "frame_cycles", out_cyc[0][71] - out_cyc[0][0], 71);
                rmode[0] = 1;
                wait_n(0, 144);
                check(0, "inputs_two_frames", in_idx[0], 64);
                vmode[0] = 2; rmode[0] = 2;
                wait_n(0, 360);
                vmode[0] = 0; rmode[0] = 0;
                wait_n(0, 390);
                #1 rst_a = 1'b1;
                @(posedge clk); #1;
                check(0, "rst_valid_next", 32'(ma.tvalid), 0);
                @(posedge clk); #1;
                rst_a = 1'b0;
                wait_n(0, 144);
                check(0, "restart_beat13_pad", out_log[0][13], 32'h00);
                check(0, "restart_beat14_in0", out_log[0][14], gen(0) & 32'hff);
`ifdef SWU_PAD_TLAST_EN
                check(0, "tlast_count", tl_q.size(), 2);
                if (tl_q.size() == 2) begin
                    check(0, "tlast_pos0", tl_q[0], 71);
                    check(0, "tlast_pos1", tl_q[1], 143);
                end
`endif
            end
            begin : run_b
                vmode[1] = 0; rmode[1] = 0;
                wait_n(1, 18);
                vmode[1] = 3;
                for (int k = 0; k < 18; k++) begin
                    check(1, "pass_data", out_log[1][k], gen(k) & 32'hffff);
                    check(1, "pass_latency", out_cyc[1][k] - in_cyc[1][k], 1);
                end
                check(1, "no_bubbles", out_cyc[1][17] - out_cyc[1][0], 17);
                vmode[1] = 2; rmode[1] = 2;
                wait_n(1, 108);
            end
            begin : run_c
                vmode[2] = 0; rmode[2] = 0;
                wait_n(2, 16);
                for (int k = 0; k < 16; k++) exp_c[k] = 32'h80;
                exp_c[2] = gen(0) & 32'hff;
                exp_c[3] = gen(1) & 32'hff;
                exp_c[6] = gen(2) & 32'hff;
                exp_c[7] = gen(3) & 32'hff;
                for (int k = 0; k < 16; k++) check(2, "asym_pad_beat", out_log[2][k], exp_c[k]);
                vmode[2] = 2; rmode[2] = 2;
                wait_n(2, 64);
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
